mem_responder: RTL and testbench

Block-granular memory responder for the cache memory port. It answers the cache's level-held mem_read/mem_write requests after a fixed programmable latency with a one-cycle mem_ready pulse. It holds a 128-bit-per-line backing store and sits below the L1 cache, as the memory model in system simulation and as an on-chip scratch memory.

---
 rtl/mem_responder_if.sv | 28 ++
 rtl/mem_responder.sv | 136 +++++++++++++
 tb/tb_mem_responder.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Cache memory port bundle between the L1 cache (master) and the
// block-granular memory responder (slave).
interface mem_responder_if;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    modport master (
        output mem_read,
        output mem_write,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency line memory responder for the cache memory port.
// Define MEM_RESP_STATS_EN to build the saturating rd_cnt/wr_cnt counters.
module mem_responder #(
    parameter int LATENCY    = 7,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic        clk,
    input  logic        proc_reset,
    mem_responder_if.slave bus,
    output logic        proto_err,
    output logic [15:0] rd_cnt,
    output logic [15:0] wr_cnt
);

    localparam int         DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    generate
        if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
            $error("mem_responder: LATENCY must be in 1..255");
        end
    endgenerate

    logic [1:0]            state;
    logic [1:0]            state_nx;
    logic [7:0]            cnt;
    logic                  op_wr;
    logic [DEPTH_LOG2-1:0] idx;
    logic [127:0]          wdata_q;
    logic [127:0]          store [DEPTH];

    logic                  req;
    logic                  both;
    logic [DEPTH_LOG2-1:0] addr_idx;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  rd_entry;
    logic                  unused_addr_hi;

    assign req      = bus.mem_read | bus.mem_write;
    assign both     = bus.mem_read & bus.mem_write;
    assign addr_idx = bus.mem_addr[DEPTH_LOG2-1:0];

    // Upper address bits alias onto the store.
    assign unused_addr_hi = ^bus.mem_addr[27:DEPTH_LOG2];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nx = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (cnt == 8'd1) begin
                    state_nx = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Read data is fetched on the edge that enters RESP; with LATENCY==1
    // that edge is the accept edge, so the index comes straight off the bus.
    always_comb begin
        rd_entry = 1'b0;
        rd_idx   = idx;
        if (state == IDLE) begin
            rd_idx   = addr_idx;
            rd_entry = req && !bus.mem_write && (LATENCY == 1);
        end else if (state == BUSY) begin
            rd_entry = (cnt == 8'd1) && !op_wr;
        end
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            op_wr         <= 1'b0;
            idx           <= '0;
            wdata_q       <= '0;
            proto_err     <= 1'b0;
            bus.mem_rdata <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req) begin
                cnt     <= LAT_M1;
                op_wr   <= bus.mem_write;
                idx     <= addr_idx;
                wdata_q <= bus.mem_wdata;
                if (both) begin
                    proto_err <= 1'b1;
                end
            end else if (state == BUSY) begin
                cnt <= cnt - 8'd1;
            end
            if (rd_entry) begin
                bus.mem_rdata <= store[rd_idx];
            end
        end
    end

    // Store is not reset; a reset during RESP drops state before this edge.
    always_ff @(posedge clk) begin
        if (state == RESP && op_wr) begin
            store[idx] <= wdata_q;
        end
    end

    assign bus.mem_ready = (state == RESP);

`ifdef MEM_RESP_STATS_EN
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            rd_cnt <= 16'd0;
            wr_cnt <= 16'd0;
        end else if (state == RESP) begin
            if (op_wr) begin
                if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
            end else begin
                if (rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
            end
        end
    end
`else
    assign rd_cnt = 16'd0;
    assign wr_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder at LATENCY=7, DEPTH_LOG2=6.
module tb_mem_responder;

    localparam int LAT = 7;

    logic        clk = 1'b0;
    logic        proc_reset;
    logic        proto_err;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mem_responder_if bus ();

    mem_responder #(
        .LATENCY   (LAT),
        .DEPTH_LOG2(6)
    ) dut (
        .clk       (clk),
        .proc_reset(proc_reset),
        .bus       (bus),
        .proto_err (proto_err),
        .rd_cnt    (rd_cnt),
        .wr_cnt    (wr_cnt)
    );

    logic [127:0] line_a5;
    logic [127:0] line_x;
    logic [127:0] line_y;
    logic [127:0] line_d;
    logic [127:0] line_e;
    logic [127:0] line_p;
    logic [127:0] line_q;

    // Drive a request at a negedge; lat counts negedges after the accept
    // edge until mem_ready is seen (-1 on timeout).
    task automatic do_txn(input logic rd, input logic wr,
                          input logic [27:0] a, input logic [127:0] d,
                          output int lat, output logic [127:0] rdata);
        @(negedge clk);
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.mem_addr  = a;
        bus.mem_wdata = d;
        @(posedge clk);
        lat   = -1;
        rdata = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.mem_ready === 1'b1) begin
                lat   = k;
                rdata = bus.mem_rdata;
                break;
            end
        end
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic test_reset();
        proc_reset    = 1'b1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        proc_reset = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (bus.mem_ready !== 1'b0)
            $display("FAIL rst_ready: got %b want 0", bus.mem_ready);
        else pass_cnt++;
        total_cnt++;
        if (bus.mem_rdata !== 128'd0)
            $display("FAIL rst_rdata: got %h want 0", bus.mem_rdata);
        else pass_cnt++;
        total_cnt++;
        if (proto_err !== 1'b0)
            $display("FAIL rst_proto_err: got %b want 0", proto_err);
        else pass_cnt++;
        total_cnt++;
        if (rd_cnt !== 16'd0 || wr_cnt !== 16'd0)
            $display("FAIL rst_cnts: got %h/%h want 0/0", rd_cnt, wr_cnt);
        else pass_cnt++;
    endtask

    task automatic test_write_read();
        int lat;
        logic [127:0] rdat;
        do_txn(1'b0, 1'b1, 28'h0000005, line_a5, lat, rdat);
        total_cnt++;
        if (lat !== LAT) $display("FAIL wr_latency: got %0d want %0d", lat, LAT);
        else pass_cnt++;
        do_txn(1'b1, 1'b0, 28'h0000005, 128'd0, lat, rdat);
        total_cnt++;
        if (lat !== LAT) $display("FAIL rd_latency: got %0d want %0d", lat, LAT);
        else pass_cnt++;
        total_cnt++;
        if (rdat !== line_a5) $display("FAIL rd_data: got %h want %h", rdat, line_a5);
        else pass_cnt++;
        total_cnt++;
        if (proto_err !== 1'b0) $display("FAIL wr_rd_proto: got %b want 0", proto_err);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat;
        int gap;
        logic first_after;
        logic [127:0] rdat;
        do_txn(1'b0, 1'b1, 28'h0000041, line_y, lat, rdat);
        @(negedge clk);
        bus.mem_write = 1'b1;
        bus.mem_addr  = 28'h0000040;
        bus.mem_wdata = line_x;
        @(posedge clk);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.mem_ready === 1'b1) begin
                lat = k;
                break;
            end
        end
        total_cnt++;
        if (lat !== LAT) $display("FAIL wb_latency: got %0d want %0d", lat, LAT);
        else pass_cnt++;
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b1;
        bus.mem_addr  = 28'h0000041;
        gap         = -1;
        first_after = 1'bx;
        rdat        = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) first_after = bus.mem_ready;
            if (bus.mem_ready === 1'b1) begin
                gap  = k;
                rdat = bus.mem_rdata;
                break;
            end
        end
        bus.mem_read = 1'b0;
        total_cnt++;
        if (first_after !== 1'b0)
            $display("FAIL ready_pulse: got %b want 0", first_after);
        else pass_cnt++;
        total_cnt++;
        if (gap !== LAT + 1) $display("FAIL refill_gap: got %0d want %0d", gap, LAT + 1);
        else pass_cnt++;
        total_cnt++;
        if (rdat !== line_y) $display("FAIL refill_data: got %h want %h", rdat, line_y);
        else pass_cnt++;
        do_txn(1'b1, 1'b0, 28'h0000040, 128'd0, lat, rdat);
        total_cnt++;
        if (rdat !== line_x) $display("FAIL wb_data: got %h want %h", rdat, line_x);
        else pass_cnt++;
    endtask

    task automatic test_alias();
        int lat;
        logic [127:0] rdat;
        do_txn(1'b0, 1'b1, 28'h0000043, line_d, lat, rdat);
        do_txn(1'b1, 1'b0, 28'h0000003, 128'd0, lat, rdat);
        total_cnt++;
        if (rdat !== line_d) $display("FAIL alias_data: got %h want %h", rdat, line_d);
        else pass_cnt++;
    endtask

    task automatic test_mid_change();
        int lat;
        logic [127:0] rdat;
        logic [127:0] held;
        @(negedge clk);
        bus.mem_write = 1'b1;
        bus.mem_addr  = 28'h0000020;
        bus.mem_wdata = line_e;
        @(posedge clk);
        #1;
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b1;
        bus.mem_addr  = 28'h0000021;
        bus.mem_wdata = line_q;
        lat  = -1;
        held = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.mem_ready === 1'b1) begin
                lat  = k;
                held = bus.mem_rdata;
                break;
            end
        end
        bus.mem_read = 1'b0;
        total_cnt++;
        if (lat !== LAT) $display("FAIL chg_latency: got %0d want %0d", lat, LAT);
        else pass_cnt++;
        total_cnt++;
        if (held !== line_d) $display("FAIL rdata_hold: got %h want %h", held, line_d);
        else pass_cnt++;
        do_txn(1'b1, 1'b0, 28'h0000020, 128'd0, lat, rdat);
        total_cnt++;
        if (rdat !== line_e) $display("FAIL chg_data: got %h want %h", rdat, line_e);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        int lat;
        logic [127:0] rdat;
        do_txn(1'b1, 1'b1, 28'h0000010, 128'h1234, lat, rdat);
        total_cnt++;
        if (lat !== LAT) $display("FAIL both_latency: got %0d want %0d", lat, LAT);
        else pass_cnt++;
        total_cnt++;
        if (proto_err !== 1'b1) $display("FAIL proto_set: got %b want 1", proto_err);
        else pass_cnt++;
        do_txn(1'b1, 1'b0, 28'h0000010, 128'd0, lat, rdat);
        total_cnt++;
        if (rdat !== 128'h1234) $display("FAIL both_data: got %h want %h", rdat, 128'h1234);
        else pass_cnt++;
        total_cnt++;
        if (proto_err !== 1'b1) $display("FAIL proto_sticky: got %b want 1", proto_err);
        else pass_cnt++;
    endtask

    task automatic test_reset_busy();
        int lat;
        logic seen;
        logic [127:0] rdat;
        do_txn(1'b0, 1'b1, 28'h0000030, line_p, lat, rdat);
        @(negedge clk);
        bus.mem_write = 1'b1;
        bus.mem_addr  = 28'h0000030;
        bus.mem_wdata = line_q;
        @(posedge clk);
        seen = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.mem_ready === 1'b1) seen = 1'b1;
            if (k == 3) begin
                proc_reset    = 1'b1;
                bus.mem_write = 1'b0;
            end
            if (k == 4) proc_reset = 1'b0;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL rstbusy_ready: got %b want 0", seen);
        else pass_cnt++;
        total_cnt++;
        if (proto_err !== 1'b0) $display("FAIL rstbusy_proto: got %b want 0", proto_err);
        else pass_cnt++;
        total_cnt++;
        if (bus.mem_rdata !== 128'd0)
            $display("FAIL rstbusy_rdata: got %h want 0", bus.mem_rdata);
        else pass_cnt++;
        do_txn(1'b1, 1'b0, 28'h0000030, 128'd0, lat, rdat);
        total_cnt++;
        if (lat !== LAT) $display("FAIL rstbusy_latency: got %0d want %0d", lat, LAT);
        else pass_cnt++;
        total_cnt++;
        if (rdat !== line_p) $display("FAIL rstbusy_data: got %h want %h", rdat, line_p);
        else pass_cnt++;
    endtask

    task automatic test_stats();
        int lat;
        logic [127:0] rdat;
        logic [15:0] exp_rd;
        logic [15:0] exp_wr;
        @(negedge clk);
        proc_reset = 1'b1;
        @(negedge clk);
        proc_reset = 1'b0;
        for (int i = 1; i <= 3; i++)
            do_txn(1'b0, 1'b1, 28'(i), line_a5, lat, rdat);
        for (int i = 1; i <= 2; i++)
            do_txn(1'b1, 1'b0, 28'(i), 128'd0, lat, rdat);
        @(negedge clk);
`ifdef MEM_RESP_STATS_EN
        exp_rd = 16'd2;
        exp_wr = 16'd3;
`else
        exp_rd = 16'd0;
        exp_wr = 16'd0;
`endif
        total_cnt++;
        if (wr_cnt !== exp_wr) $display("FAIL stats_wr: got %0d want %0d", wr_cnt, exp_wr);
        else pass_cnt++;
        total_cnt++;
        if (rd_cnt !== exp_rd) $display("FAIL stats_rd: got %0d want %0d", rd_cnt, exp_rd);
        else pass_cnt++;
    endtask

    initial begin
        line_a5 = {16{8'hA5}};
        line_x  = {4{32'h1357_9BDF}};
        line_y  = {4{32'h0BAD_CAFE}};
        line_d  = {4{32'hDEAD_BEEF}};
        line_e  = {4{32'h7E57_0E0E}};
        line_p  = {4{32'h5555_AAAA}};
        line_q  = {4{32'h3C3C_C3C3}};
        test_reset();
        test_write_read();
        test_back_to_back();
        test_alias();
        test_mid_change();
        test_simultaneous();
        test_reset_busy();
        test_stats();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
